// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Unsigned variants exist only for loads.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      LB, LH, LW: ok = 1'b1;
      LBU, LHU:   ok = ~we;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store lane replication and load lane select/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  off_eff;
  logic [31:0] shifted;

  // Offset bits below the access size are ignored, so a misaligned access
  // behaves as if aligned down.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   off_eff = off_i;
      2'b01:   off_eff = {off_i[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  assign shifted = rword_i >> {off_eff, 3'b000};

  always_comb begin
    be_o    = '0;
    wlane_o = '0;
    rdata_o = '0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_eff;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be_o    = 4'b0011 << off_eff;
        wlane_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wlane_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging the datapath to a req/ack word bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  lsu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        done_q, fault_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;

  logic        in_idle, trap, legal;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wlane, al_rdata;

  assign in_idle = (state_q == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(funct3, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign legal = funct3_legal(funct3, mem_write) & ~trap;

  // One aligner serves both directions: live inputs while capturing in IDLE,
  // the captured access while waiting for the read word.
  assign al_funct3 = in_idle ? funct3 : funct3_q;
  assign al_off    = in_idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3_i (al_funct3),
    .off_i    (al_off),
    .wdata_i  (wdata),
    .rword_i  (bus_rdata),
    .be_o     (al_be),
    .wlane_o  (al_wlane),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            if (legal) begin
              state_q     <= ST_BUS;
              cnt_q       <= '0;
              funct3_q    <= funct3;
              off_q       <= addr[1:0];
              we_q        <= mem_write;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_wdata_q <= al_wlane;
              bus_be_q    <= al_be;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack || cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            fault_q     <= ~bus_ack;
            rdata_q     <= (bus_ack && !we_q) ? al_rdata : '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          fault_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall     = (in_idle && mem_valid) || (state_q == ST_BUS);
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout and reset sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, mem_valid, mem_write, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, done, fault, bus_req, bus_we;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.BUS_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int unsigned dly;
    logic        exp_bus;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] brd, input int unsigned dly,
                              input logic eb, input logic [3:0] be, input logic [31:0] ba,
                              input logic [31:0] bwd, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.brdata = brd; v.dly = dly;
    v.exp_bus = eb; v.be = be; v.baddr = ba; v.bwdata = bwd; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] held;
    mem_valid = 1'b1; mem_write = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    bus_rdata = '0;
    #1;
    chk($sformatf("v%0d stall_idle", idx), 32'(stall), 32'd1);
    @(posedge clk); #1;
    if (v.exp_bus) begin
      chk($sformatf("v%0d bus_req", idx), 32'(bus_req), 32'd1);
      chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.we));
      chk($sformatf("v%0d bus_addr", idx), bus_addr, v.baddr);
      chk($sformatf("v%0d bus_be", idx), 32'(bus_be), 32'(v.be));
      chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwdata);
      chk($sformatf("v%0d done_bus", idx), 32'(done), 32'd0);
      for (int unsigned k = 0; k < v.dly; k++) begin
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d bus_req_held", idx), 32'(bus_req), 32'd1);
      chk($sformatf("v%0d bus_addr_held", idx), bus_addr, v.baddr);
      bus_ack = 1'b1; bus_rdata = v.brdata;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = '0;
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d fault", idx), 32'(fault), 32'd0);
      chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
      held = v.rdata;
    end else begin
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d fault", idx), 32'(fault), 32'd1);
      chk($sformatf("v%0d rdata", idx), rdata, 32'd0);
      chk($sformatf("v%0d bus_be", idx), 32'(bus_be), 32'd0);
      held = 32'd0;
    end
    chk($sformatf("v%0d bus_req_done", idx), 32'(bus_req), 32'd0);
    chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d done_clear", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d rdata_held", idx), rdata, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; mem_valid = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

    //          we    f3      addr          wdata         brdata        dly bus be       baddr         bwdata        rdata
    vecs.push_back(mk(1'b1, SW,    32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(1'b0, LB,    32'h103, 32'h0,        32'h80FF0000, 0, 1, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1'b0, LBU,   32'h103, 32'h0,        32'h80FF0000, 2, 1, 4'b1000, 32'h100, 32'h0,        32'h00000080));
    vecs.push_back(mk(1'b1, SH,    32'h102, 32'h00001234, 32'h0,        1, 1, 4'b1100, 32'h100, 32'h12341234, 32'h0));
    vecs.push_back(mk(1'b1, SB,    32'h201, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 32'h200, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1'b0, LB,    32'h201, 32'h0,        32'h12347F56, 0, 1, 4'b0010, 32'h200, 32'h0,        32'h0000007F));
    vecs.push_back(mk(1'b0, LH,    32'h102, 32'h0,        32'h80017FFF, 0, 1, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1'b0, LHU,   32'h100, 32'h0,        32'h8001F00D, 0, 1, 4'b0011, 32'h100, 32'h0,        32'h0000F00D));
    vecs.push_back(mk(1'b0, LW,    32'h104, 32'h0,        32'h12345678, 1, 1, 4'b1111, 32'h104, 32'h0,        32'h12345678));
    vecs.push_back(mk(1'b0, 3'b011, 32'h300, 32'h0,       32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1'b1, LBU,   32'h300, 32'h55,       32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1'b0, 3'b110, 32'h300, 32'h0,       32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b111, 32'h300, 32'h0,       32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(1'b0, LW,    32'h101, 32'h0,        32'hCAFEF00D, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1'b0, LH,    32'h103, 32'h0,        32'h80017FFF, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h0));
`else
    vecs.push_back(mk(1'b0, LW,    32'h101, 32'h0,        32'hCAFEF00D, 0, 1, 4'b1111, 32'h100, 32'h0,        32'hCAFEF00D));
    vecs.push_back(mk(1'b0, LH,    32'h103, 32'h0,        32'h80017FFF, 0, 1, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Load that makes rdata nonzero, then a load that never gets an ack.
    run_vec(mk(1'b0, LW, 32'h500, 32'h0, 32'hA5A5A5A5, 0, 1, 4'b1111, 32'h500, 32'h0, 32'hA5A5A5A5), 100);
    mem_valid = 1'b1; mem_write = 1'b0; funct3 = LW; addr = 32'h400;
    @(posedge clk); #1;
    n = 0;
    while (bus_req === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout bus_cycles", 32'(n), 32'd16);
    chk("timeout done", 32'(done), 32'd1);
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout rdata", rdata, 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("timeout done_clear", 32'(done), 32'd0);

    // Reset in the middle of a bus transaction.
    run_vec(mk(1'b0, LW, 32'h600, 32'h0, 32'h5A5A5A5A, 0, 1, 4'b1111, 32'h600, 32'h0, 32'h5A5A5A5A), 101);
    mem_valid = 1'b1; funct3 = LW; addr = 32'h700;
    @(posedge clk); #1;
    chk("rstbus bus_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstbus bus_req", 32'(bus_req), 32'd0);
    chk("rstbus done", 32'(done), 32'd0);
    chk("rstbus stall", 32'(stall), 32'd0);
    chk("rstbus rdata", rdata, 32'd0);
    chk("rstbus bus_addr", bus_addr, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("stray_ack done", 32'(done), 32'd0);
    chk("stray_ack rdata", rdata, 32'd0);
    bus_ack = 1'b0; bus_rdata = '0;
    @(posedge clk); #1;
    chk("stray_ack done_late", 32'(done), 32'd0);
    chk("stray_ack bus_req", 32'(bus_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: BUS_TIMEOUT, default 16, maximum number of BUS-state cycles to wait for bus_ack before faulting.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_valid  input  1  datapath requests a load/store for the current instruction.
REQ-006 mem_write  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 addr  input  32  byte address (datapath ALUResult).
REQ-009 wdata  input  32  store data (datapath WriteData).
REQ-010 rdata  output  32  aligned, extended load data (datapath ReadData).
REQ-011 stall  output  1  hold PC/register write while high.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 fault  output  1  access error, valid only with done.
REQ-014 bus_req, bus_we  output  1 each  bus request, bus write enable.
REQ-015 bus_addr  output  32  word-aligned address (bits [1:0] = 00).
REQ-016 bus_wdata  output  32, bus_be  output  4  lane-shifted store data, byte enables.
REQ-017 bus_ack  input  1, bus_rdata  input  32  bus completion, read word.

Function
REQ-018 FSM states: IDLE, BUS, DONE.
REQ-019 IDLE: when mem_valid=1 and the access is legal, register addr/wdata/funct3/mem_write and go to BUS; when illegal, go directly to DONE with fault=1 and no bus activity.
REQ-020 Illegal: funct3 in {011,110,111}; funct3 100/101 with mem_write=1; misaligned access per REQ-031.
REQ-021 BUS: bus_req=1 and all bus_* outputs are registered and stable until the cycle in which bus_ack=1; on that cycle capture the load result and go to DONE.
REQ-022 Timeout: counter clears on BUS entry and increments each BUS cycle without ack; when it reaches BUS_TIMEOUT, drop bus_req, go to DONE with fault=1, rdata=0.
REQ-023 DONE: done=1 for exactly one cycle, then unconditional return to IDLE; mem_valid is sampled only in IDLE.
REQ-024 stall = (IDLE and mem_valid) or BUS; stall=0 in DONE.
REQ-025 Minimum latency 3 cycles (IDLE capture, BUS with ack, DONE).
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-027 Store data replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-028 Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through; stores leave rdata=0.
REQ-029 rdata held from DONE until the next DONE; bus_ack outside BUS is ignored.

Reset
REQ-030 Reset forces IDLE, timeout counter 0, and rdata=0, stall=0, done=0, fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0 after the edge; reset in BUS abandons the transaction with no done pulse.

Configuration
REQ-031 LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 is illegal (fault, no bus). Undefined: the offending low address bits are treated as 0 and the access proceeds.

Structure
REQ-032 Package lsu_pkg holds the state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-033 Combinational sub-module lsu_align performs byte-enable generation, store lane replication, and load lane select/extension.

Verification
REQ-034 SW addr=0x100, wdata=0xDEADBEEF, ack in first BUS cycle -> bus_be=1111, bus_addr=0x100, done in cycle 3, fault=0.
REQ-035 LB addr=0x103, bus_rdata=0x80FF_0000 -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-036 SH addr=0x102, wdata=0x1234 -> bus_be=1100, bus_wdata=0x12341234.
REQ-037 bus_ack never asserted, BUS_TIMEOUT=16 -> bus_req drops after 16 BUS cycles, done=1, fault=1, rdata=0.
REQ-038 LW addr=0x101 -> with LSU_MISALIGN_TRAP_EN: fault, bus_req never set; without: bus_addr=0x100.
REQ-039 reset asserted during BUS -> next cycle IDLE, bus_req=0, no done pulse.
